// File: rtl/a2d_spi_responder_pkg.sv
// Shared constants and state encoding for the A2D SPI responder.
package a2d_resp_pkg;

    localparam int unsigned NUM_CH      = 8;
    localparam int unsigned CH_W        = 3;
    localparam int unsigned DATA_W      = 12;
    localparam int unsigned FRAME_W     = 16;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned CMD_CH_MSB  = 13;
    localparam int unsigned CMD_CH_LSB  = 11;
    localparam int unsigned CNT_W       = 5;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT
    } state_t;

endpackage

// File: rtl/a2d_spi_responder_sig_synch.sv
// Multi-flop synchronizer with one extra flop for rise/fall pulse detection.
// Flops are not reset so the chain keeps tracking the pin through a reset.
module sig_synch #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_sig,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge i_clk) begin
        r_sync <= {r_sync[STAGES-2:0], i_sig};
        r_prev <= r_sync[STAGES-1];
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise =  r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] &  r_prev;

endmodule

// File: rtl/a2d_spi_responder.sv
// SPI slave emulating an 8-channel 12-bit A2D: command frame picks a channel, next frame returns it.
// Optional macro CHNL_TAG_EN: response upper nibble carries {1'b0, cmd_chnl}.
module a2d_spi_responder
    import a2d_resp_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_SS_n,
    input  logic                     i_SCLK,
    input  logic                     i_MOSI,
    input  logic [NUM_CH*DATA_W-1:0] i_chnl_data,
    output logic                     o_MISO,
    output logic                     o_cmd_vld,
    output logic [CH_W-1:0]          o_cmd_chnl,
    output logic                     o_xfer_err
);

    logic w_ss_n, w_ss_rise, w_ss_fall;
    logic w_sclk, w_sclk_rise, w_sclk_fall;

    sig_synch #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .i_clk  (i_clk),
        .i_sig  (i_SS_n),
        .o_sync (w_ss_n),
        .o_rise (w_ss_rise),
        .o_fall (w_ss_fall)
    );

    sig_synch #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .i_clk  (i_clk),
        .i_sig  (i_SCLK),
        .o_sync (w_sclk),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    // MOSI gets the same depth plus one so it lines up with the SCLK edge pulse.
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_mosi;
    always_ff @(posedge i_clk) begin
        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_MOSI};
        r_mosi      <= r_mosi_sync[SYNC_STAGES-1];
    end

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [FRAME_W-1:0] r_tx_shft, w_tx_shft_nxt;
    logic [FRAME_W-1:0] r_rx_shft, w_rx_shft_nxt;
    logic [CH_W-1:0]    r_cmd_chnl, w_cmd_chnl_nxt;
    logic               r_cmd_vld, w_cmd_vld_nxt;
    logic               r_xfer_err, w_xfer_err_nxt;

    logic [DATA_W-1:0]         w_sample;
    logic [FRAME_W-DATA_W-1:0] w_tag;
    logic [FRAME_W-1:0]        w_resp;

    always_comb begin
        w_sample = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (r_cmd_chnl == CH_W'(k)) begin
                w_sample = i_chnl_data[k*DATA_W +: DATA_W];
            end
        end
    end

`ifdef CHNL_TAG_EN
    assign w_tag = {1'b0, r_cmd_chnl};
`else
    assign w_tag = '0;
`endif

    assign w_resp = {w_tag, w_sample};

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_tx_shft_nxt  = r_tx_shft;
        w_rx_shft_nxt  = r_rx_shft;
        w_cmd_chnl_nxt = r_cmd_chnl;
        w_cmd_vld_nxt  = 1'b0;
        w_xfer_err_nxt = 1'b0;
        unique case (r_state)
            WAIT_IDLE: begin
                if (w_ss_n) w_state_nxt = IDLE;
            end
            IDLE: begin
                if (w_ss_fall) begin
                    w_state_nxt   = SHIFT;
                    w_tx_shft_nxt = w_resp;
                    w_bit_cnt_nxt = '0;
                end
            end
            SHIFT: begin
                if (w_ss_rise) begin
                    w_state_nxt = IDLE;
                    if (r_bit_cnt == CNT_FULL) begin
                        w_cmd_chnl_nxt = r_rx_shft[CMD_CH_MSB:CMD_CH_LSB];
                        w_cmd_vld_nxt  = 1'b1;
                    end else begin
                        w_xfer_err_nxt = 1'b1;
                    end
                end else begin
                    if (w_sclk_rise) begin
                        w_rx_shft_nxt = {r_rx_shft[FRAME_W-2:0], r_mosi};
                        if (r_bit_cnt != CNT_SAT) w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                    // SCLK idles high, so the leading fall precedes any rise; holding until
                    // the first rise keeps bit 15 on MISO for the master's first sample.
                    if (w_sclk_fall && (r_bit_cnt != '0)) begin
                        w_tx_shft_nxt = {r_tx_shft[FRAME_W-2:0], 1'b0};
                    end
                end
            end
            default: w_state_nxt = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= WAIT_IDLE;
            r_bit_cnt  <= '0;
            r_tx_shft  <= '0;
            r_rx_shft  <= '0;
            r_cmd_chnl <= '0;
            r_cmd_vld  <= 1'b0;
            r_xfer_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_tx_shft  <= w_tx_shft_nxt;
            r_rx_shft  <= w_rx_shft_nxt;
            r_cmd_chnl <= w_cmd_chnl_nxt;
            r_cmd_vld  <= w_cmd_vld_nxt;
            r_xfer_err <= w_xfer_err_nxt;
        end
    end

    assign o_MISO     = (r_state == SHIFT) & r_tx_shft[FRAME_W-1];
    assign o_cmd_vld  = r_cmd_vld;
    assign o_cmd_chnl = r_cmd_chnl;
    assign o_xfer_err = r_xfer_err;

endmodule
